muntjac_rvfi_trace_queue: RTL and testbench

MUNTJAC_RVFI_TRACE_QUEUE -- requirements
Module: muntjac_rvfi_trace_queue

---
 rtl/muntjac_rvfi_trace_queue.sv | 160 ++++++++++++++++
 tb/tb_muntjac_rvfi_trace_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muntjac_rvfi_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : muntjac_rvfi_trace_queue
// Brief    : Circular queue of retired-instruction (RVFI) trace records with
//            order stamping, sticky drop flag and an in-order halt packet.
// Revision : 1.0 - initial release
// ============================================================================
module muntjac_rvfi_trace_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        trace_valid_i,
  input  logic [63:0] trace_pc_i,
  input  logic [63:0] trace_pc_wdata_i,
  input  logic [31:0] trace_insn_i,
  input  logic [4:0]  trace_rd_addr_i,
  input  logic [63:0] trace_rd_wdata_i,
  input  logic [63:0] trace_mem_addr_i,
  input  logic [63:0] trace_mem_wdata_i,
  input  logic        trace_trap_i,

  input  logic        halt_req_i,
  input  logic        clear_i,

  output logic        pkt_valid_o,
  input  logic        pkt_ready_i,
  output logic [63:0] pkt_order_o,
  output logic        pkt_halt_o,
  output logic [63:0] pkt_pc_o,
  output logic [63:0] pkt_pc_wdata_o,
  output logic [31:0] pkt_insn_o,
  output logic [4:0]  pkt_rd_addr_o,
  output logic [63:0] pkt_rd_wdata_o,
  output logic [63:0] pkt_mem_addr_o,
  output logic [63:0] pkt_mem_wdata_o,
  output logic        pkt_trap_o,

  output logic        overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Storage (deliberately not reset; validity is tracked by count alone)
  logic [63:0] mem_order     [DEPTH];
  logic        mem_halt      [DEPTH];
  logic [63:0] mem_pc        [DEPTH];
  logic [63:0] mem_pc_wdata  [DEPTH];
  logic [31:0] mem_insn      [DEPTH];
  logic [4:0]  mem_rd_addr   [DEPTH];
  logic [63:0] mem_rd_wdata  [DEPTH];
  logic [63:0] mem_mem_addr  [DEPTH];
  logic [63:0] mem_mem_wdata [DEPTH];
  logic        mem_trap      [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      order_cnt;
  logic             halt_pending;
  logic             overflow;

  logic deq;
  logic space;
  logic trace_enq;
  logic halt_enq;
  logic enq;
  logic drop;

  // Handshake and enqueue arbitration; a trace record always beats the halt
  // entry so the halt lands behind every record accepted so far.
  always_comb begin
    deq       = (count != '0) && pkt_ready_i;
    space     = (count < FULL_COUNT) || deq;
    trace_enq = trace_valid_i && space;
    drop      = trace_valid_i && !space;
    halt_enq  = halt_pending && !trace_enq && space;
    enq       = trace_enq || halt_enq;
  end

  // Control state: pointers, occupancy, order counter, halt and overflow flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      order_cnt    <= '0;
      halt_pending <= 1'b0;
      overflow     <= 1'b0;
    end else if (clear_i) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      order_cnt    <= '0;
      halt_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (deq && !enq) begin
        count <= count - 1'b1;
      end
      if (trace_enq) begin
        order_cnt <= order_cnt + 64'd1;
      end
      // A request arriving while one is pending (or enqueueing) merges into it
      if (halt_enq) begin
        halt_pending <= 1'b0;
      end else if (halt_req_i) begin
        halt_pending <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry write; a halt entry carries only its order and the halt marker
  always_ff @(posedge clk_i) begin
    if (enq && !clear_i) begin
      mem_order[wr_ptr]     <= order_cnt;
      mem_halt[wr_ptr]      <= !trace_enq;
      mem_pc[wr_ptr]        <= trace_enq ? trace_pc_i        : 64'd0;
      mem_pc_wdata[wr_ptr]  <= trace_enq ? trace_pc_wdata_i  : 64'd0;
      mem_insn[wr_ptr]      <= trace_enq ? trace_insn_i      : 32'd0;
      mem_rd_addr[wr_ptr]   <= trace_enq ? trace_rd_addr_i   : 5'd0;
      mem_rd_wdata[wr_ptr]  <= trace_enq ? trace_rd_wdata_i  : 64'd0;
      mem_mem_addr[wr_ptr]  <= trace_enq ? trace_mem_addr_i  : 64'd0;
      mem_mem_wdata[wr_ptr] <= trace_enq ? trace_mem_wdata_i : 64'd0;
      mem_trap[wr_ptr]      <= trace_enq ? trace_trap_i      : 1'b0;
    end
  end

  // Output view of the head entry; valid follows occupancy directly
  always_comb begin
    pkt_valid_o     = (count != '0);
    pkt_order_o     = mem_order[rd_ptr];
    pkt_halt_o      = mem_halt[rd_ptr];
    pkt_pc_o        = mem_pc[rd_ptr];
    pkt_pc_wdata_o  = mem_pc_wdata[rd_ptr];
    pkt_insn_o      = mem_insn[rd_ptr];
    pkt_rd_addr_o   = mem_rd_addr[rd_ptr];
    pkt_rd_wdata_o  = mem_rd_wdata[rd_ptr];
    pkt_mem_addr_o  = mem_mem_addr[rd_ptr];
    pkt_mem_wdata_o = mem_mem_wdata[rd_ptr];
    pkt_trap_o      = mem_trap[rd_ptr];
    overflow_o      = overflow;
  end

endmodule
`default_nettype wire

// File: tb/tb_muntjac_rvfi_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_muntjac_rvfi_trace_queue
// Brief    : Directed self-checking bench for muntjac_rvfi_trace_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muntjac_rvfi_trace_queue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        trace_valid_i = 1'b0;
  logic [63:0] trace_pc_i = '0;
  logic [63:0] trace_pc_wdata_i = '0;
  logic [31:0] trace_insn_i = '0;
  logic [4:0]  trace_rd_addr_i = '0;
  logic [63:0] trace_rd_wdata_i = '0;
  logic [63:0] trace_mem_addr_i = '0;
  logic [63:0] trace_mem_wdata_i = '0;
  logic        trace_trap_i = 1'b0;
  logic        halt_req_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        pkt_ready_i = 1'b0;
  logic        pkt_valid_o;
  logic [63:0] pkt_order_o;
  logic        pkt_halt_o;
  logic [63:0] pkt_pc_o;
  logic [63:0] pkt_pc_wdata_o;
  logic [31:0] pkt_insn_o;
  logic [4:0]  pkt_rd_addr_o;
  logic [63:0] pkt_rd_wdata_o;
  logic [63:0] pkt_mem_addr_o;
  logic [63:0] pkt_mem_wdata_o;
  logic        pkt_trap_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  muntjac_rvfi_trace_queue #(.DEPTH(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .trace_valid_i     (trace_valid_i),
    .trace_pc_i        (trace_pc_i),
    .trace_pc_wdata_i  (trace_pc_wdata_i),
    .trace_insn_i      (trace_insn_i),
    .trace_rd_addr_i   (trace_rd_addr_i),
    .trace_rd_wdata_i  (trace_rd_wdata_i),
    .trace_mem_addr_i  (trace_mem_addr_i),
    .trace_mem_wdata_i (trace_mem_wdata_i),
    .trace_trap_i      (trace_trap_i),
    .halt_req_i        (halt_req_i),
    .clear_i           (clear_i),
    .pkt_valid_o       (pkt_valid_o),
    .pkt_ready_i       (pkt_ready_i),
    .pkt_order_o       (pkt_order_o),
    .pkt_halt_o        (pkt_halt_o),
    .pkt_pc_o          (pkt_pc_o),
    .pkt_pc_wdata_o    (pkt_pc_wdata_o),
    .pkt_insn_o        (pkt_insn_o),
    .pkt_rd_addr_o     (pkt_rd_addr_o),
    .pkt_rd_wdata_o    (pkt_rd_wdata_o),
    .pkt_mem_addr_o    (pkt_mem_addr_o),
    .pkt_mem_wdata_o   (pkt_mem_wdata_o),
    .pkt_trap_o        (pkt_trap_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Record k carries recognisable, per-field distinct values
  function automatic logic [63:0] f_pc(int k);        return {32'hA000_0000, 32'(k)}; endfunction
  function automatic logic [63:0] f_pc_wdata(int k);  return {32'hB000_0000, 32'(k)}; endfunction
  function automatic logic [31:0] f_insn(int k);      return 32'h0013_0000 | 32'(k);  endfunction
  function automatic logic [4:0]  f_rd_addr(int k);   return 5'(k + 1);               endfunction
  function automatic logic [63:0] f_rd_wdata(int k);  return {32'hC000_0000, 32'(k)}; endfunction
  function automatic logic [63:0] f_mem_addr(int k);  return {32'hD000_0000, 32'(k)}; endfunction
  function automatic logic [63:0] f_mem_wdata(int k); return {32'hE000_0000, 32'(k)}; endfunction
  function automatic logic        f_trap(int k);      return 1'((k >> 1) & 1);        endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int k, input logic [63:0] order);
    chk({tag, ".valid"}, 64'(pkt_valid_o), 64'd1);
    chk({tag, ".order"}, pkt_order_o, order);
    chk({tag, ".halt"}, 64'(pkt_halt_o), 64'd0);
    chk({tag, ".pc"}, pkt_pc_o, f_pc(k));
    chk({tag, ".pc_wdata"}, pkt_pc_wdata_o, f_pc_wdata(k));
    chk({tag, ".insn"}, 64'(pkt_insn_o), 64'(f_insn(k)));
    chk({tag, ".rd_addr"}, 64'(pkt_rd_addr_o), 64'(f_rd_addr(k)));
    chk({tag, ".rd_wdata"}, pkt_rd_wdata_o, f_rd_wdata(k));
    chk({tag, ".mem_addr"}, pkt_mem_addr_o, f_mem_addr(k));
    chk({tag, ".mem_wdata"}, pkt_mem_wdata_o, f_mem_wdata(k));
    chk({tag, ".trap"}, 64'(pkt_trap_o), 64'(f_trap(k)));
  endtask

  task automatic chk_halt(input string tag, input logic [63:0] order);
    chk({tag, ".valid"}, 64'(pkt_valid_o), 64'd1);
    chk({tag, ".order"}, pkt_order_o, order);
    chk({tag, ".halt"}, 64'(pkt_halt_o), 64'd1);
    chk({tag, ".pc"}, pkt_pc_o, 64'd0);
    chk({tag, ".insn"}, 64'(pkt_insn_o), 64'd0);
    chk({tag, ".rd_wdata"}, pkt_rd_wdata_o, 64'd0);
    chk({tag, ".trap"}, 64'(pkt_trap_o), 64'd0);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(pkt_valid_o), 64'd0);
  endtask

  task automatic drive_rec(input int k);
    trace_valid_i     = 1'b1;
    trace_pc_i        = f_pc(k);
    trace_pc_wdata_i  = f_pc_wdata(k);
    trace_insn_i      = f_insn(k);
    trace_rd_addr_i   = f_rd_addr(k);
    trace_rd_wdata_i  = f_rd_wdata(k);
    trace_mem_addr_i  = f_mem_addr(k);
    trace_mem_wdata_i = f_mem_wdata(k);
    trace_trap_i      = f_trap(k);
  endtask

  // Advance one clock; inputs were set before, outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
    trace_valid_i = 1'b0;
    halt_req_i    = 1'b0;
    clear_i       = 1'b0;
  endtask

  task automatic rec_step(input int k);
    drive_rec(k);
    step();
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset.valid", 64'(pkt_valid_o), 64'd0);
    chk("reset.overflow", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;

    // ---------------- ordering: three back-to-back records ----------------
    pkt_ready_i = 1'b1;
    rec_step(1); chk_rec("ord0", 1, 64'd0);
    rec_step(2); chk_rec("ord1", 2, 64'd1);
    rec_step(3); chk_rec("ord2", 3, 64'd2);
    step();      chk_empty("ord.drained");

    // ---------------- overflow: six records, no ready ----------------
    clear_i = 1'b1; step();
    pkt_ready_i = 1'b0;
    rec_step(10); chk_rec("ovf.head", 10, 64'd0);
    rec_step(11);
    rec_step(12);
    rec_step(13); chk("ovf.not_yet", 64'(overflow_o), 64'd0);
    rec_step(14); chk("ovf.set", 64'(overflow_o), 64'd1);
    rec_step(15); chk_rec("ovf.head_kept", 10, 64'd0);
    pkt_ready_i = 1'b1;
    step(); chk_rec("ovf.e1", 11, 64'd1);
    step(); chk_rec("ovf.e2", 12, 64'd2);
    step(); chk_rec("ovf.e3", 13, 64'd3);
    step(); chk_empty("ovf.four_only");
    rec_step(16); chk_rec("ovf.next", 16, 64'd4);
    chk("ovf.sticky", 64'(overflow_o), 64'd1);
    step(); chk_empty("ovf.drained");

    // ---------------- full with simultaneous enqueue/dequeue ----------------
    clear_i = 1'b1; step();
    chk("full.clr_ovf", 64'(overflow_o), 64'd0);
    pkt_ready_i = 1'b0;
    rec_step(20); rec_step(21); rec_step(22); rec_step(23);
    chk_rec("full.head", 20, 64'd0);
    pkt_ready_i = 1'b1;
    rec_step(24); chk_rec("full.swap", 21, 64'd1);
    chk("full.no_ovf", 64'(overflow_o), 64'd0);
    step(); chk_rec("full.e2", 22, 64'd2);
    step(); chk_rec("full.e3", 23, 64'd3);
    step(); chk_rec("full.e4", 24, 64'd4);
    step(); chk_empty("full.drained");
    chk("full.no_ovf_end", 64'(overflow_o), 64'd0);

    // ---------------- halt ordering ----------------
    clear_i = 1'b1; step();
    pkt_ready_i = 1'b0;
    rec_step(30); rec_step(31);
    halt_req_i = 1'b1; rec_step(32);
    halt_req_i = 1'b1; step();
    chk_rec("halt.e0", 30, 64'd0);
    pkt_ready_i = 1'b1;
    step(); chk_rec("halt.e1", 31, 64'd1);
    step(); chk_rec("halt.e2", 32, 64'd2);
    step(); chk_halt("halt.pkt", 64'd3);
    step(); chk_empty("halt.after");
    step(); chk_empty("halt.single");
    rec_step(33); chk_rec("halt.next_order", 33, 64'd3);
    step(); chk_empty("halt.drained");

    // ---------------- clear with entries, overflow and pending halt ----------------
    clear_i = 1'b1; step();
    pkt_ready_i = 1'b0;
    rec_step(40); rec_step(41); rec_step(42); rec_step(43); rec_step(44);
    chk("clr.ovf_set", 64'(overflow_o), 64'd1);
    pkt_ready_i = 1'b1;
    step(); chk_rec("clr.e1", 41, 64'd1);
    halt_req_i = 1'b1; rec_step(45); chk_rec("clr.e2", 42, 64'd2);
    pkt_ready_i = 1'b0;
    clear_i = 1'b1; halt_req_i = 1'b1; rec_step(46);
    chk_empty("clr.valid");
    chk("clr.ovf", 64'(overflow_o), 64'd0);
    step(); chk_empty("clr.no_halt");
    rec_step(47); chk_rec("clr.order0", 47, 64'd0);
    pkt_ready_i = 1'b1;
    step(); chk_empty("clr.drained");

    // ---------------- asynchronous reset mid-operation ----------------
    pkt_ready_i = 1'b0;
    rec_step(50); rec_step(51);
    chk_rec("rst.pre", 50, 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_empty("rst.async");
    chk("rst.ovf", 64'(overflow_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rec_step(52); chk_rec("rst.order0", 52, 64'd0);
    pkt_ready_i = 1'b1;
    step(); chk_empty("rst.only_one");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
